// File: rtl/palette_lookup_arbiter.sv
// Shared 16x24 sprite palette with round-robin lookup arbitration between NUM_REQ fetch units.
// Loader writes take priority over lookups; responses return one cycle after the grant.
module palette_lookup_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int IDX_W           = 4,
  parameter int COLOR_W         = 24,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]   i_req_idx,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  output logic [COLOR_W-1:0]         o_rsp_color,
  output logic                       o_rsp_transparent,
  input  logic                       i_rsp_ready,
  input  logic                       i_wr_en,
  input  logic [IDX_W-1:0]           i_wr_addr,
  input  logic [COLOR_W-1:0]         i_wr_color
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int DEPTH = 2 ** IDX_W;

  logic [COLOR_W-1:0] r_palette [DEPTH];
  logic [ID_W-1:0]    r_rrPtr;
  logic               r_rspValid;
  logic [ID_W-1:0]    r_rspId;
  logic [COLOR_W-1:0] r_rspColor;
  logic               r_rspTransparent;

  logic               w_canIssue;
  logic               w_grantHit;
  logic [NUM_REQ-1:0] w_grantVec;
  logic [ID_W-1:0]    w_grantId;
  logic [IDX_W-1:0]   w_grantIdx;
  logic [ID_W-1:0]    w_nextPtr;
  int                 w_cand;

  // A loader write or a stalled, unconsumed response blocks any new lookup.
  assign w_canIssue = !i_rst && !i_wr_en && (!r_rspValid || i_rsp_ready);

  always_comb begin
    w_grantHit = 1'b0;
    w_grantVec = '0;
    w_grantId  = '0;
    w_cand     = 0;
    if (w_canIssue) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        w_cand = (int'(r_rrPtr) + off) % NUM_REQ;
        if (!w_grantHit && i_req_valid[w_cand]) begin
          w_grantHit         = 1'b1;
          w_grantVec[w_cand] = 1'b1;
          w_grantId          = ID_W'(w_cand);
        end
      end
    end
  end

  assign w_grantIdx = i_req_idx[w_grantId*IDX_W +: IDX_W];
  assign w_nextPtr  = (w_grantId == ID_W'(NUM_REQ - 1)) ? '0 : w_grantId + ID_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_palette[e] <= '0;
      end
    end else if (i_wr_en) begin
      r_palette[i_wr_addr] <= i_wr_color;
    end
  end

  // A registered response keeps its colour even if the loader rewrites that entry later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rrPtr          <= '0;
      r_rspValid       <= 1'b0;
      r_rspId          <= '0;
      r_rspColor       <= '0;
      r_rspTransparent <= 1'b0;
    end else if (w_grantHit) begin
      r_rrPtr          <= w_nextPtr;
      r_rspValid       <= 1'b1;
      r_rspId          <= w_grantId;
      r_rspColor       <= r_palette[w_grantIdx];
      r_rspTransparent <= (w_grantIdx == IDX_W'(TRANSPARENT_IDX));
    end else if (r_rspValid && i_rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign o_req_ready       = w_grantVec;
  assign o_rsp_valid       = r_rspValid;
  assign o_rsp_id          = r_rspId;
  assign o_rsp_color       = r_rspColor;
  assign o_rsp_transparent = r_rspTransparent;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed bench for palette_lookup_arbiter: reset, load, fairness, backpressure, write priority, mid-stream reset.
module tb_palette_lookup_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req_valid;
  logic [15:0] i_req_idx;
  logic [3:0]  o_req_ready;
  logic        o_rsp_valid;
  logic [1:0]  o_rsp_id;
  logic [23:0] o_rsp_color;
  logic        o_rsp_transparent;
  logic        i_rsp_ready;
  logic        i_wr_en;
  logic [3:0]  i_wr_addr;
  logic [23:0] i_wr_color;

  int checkCount = 0;
  int errorCount = 0;

  palette_lookup_arbiter #(
    .NUM_REQ(4), .IDX_W(4), .COLOR_W(24), .TRANSPARENT_IDX(0)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req_valid(i_req_valid),
    .i_req_idx(i_req_idx),
    .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_id(o_rsp_id),
    .o_rsp_color(o_rsp_color),
    .o_rsp_transparent(o_rsp_transparent),
    .i_rsp_ready(i_rsp_ready),
    .i_wr_en(i_wr_en),
    .i_wr_addr(i_wr_addr),
    .i_wr_color(i_wr_color)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic [15:0] idx,
                               input logic rspReady, input logic wrEn, input logic [3:0] wrAddr,
                               input logic [23:0] wrColor);
    i_rst       = rst;
    i_req_valid = valid;
    i_req_idx   = idx;
    i_rsp_ready = rspReady;
    i_wr_en     = wrEn;
    i_wr_addr   = wrAddr;
    i_wr_color  = wrColor;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkRsp(input string tag, input logic [1:0] id, input logic [23:0] color, input logic transp);
    checkOutput({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
    checkOutput({tag, "_id"}, 32'(o_rsp_id), 32'(id));
    checkOutput({tag, "_color"}, 32'(o_rsp_color), 32'(color));
    checkOutput({tag, "_transp"}, 32'(o_rsp_transparent), 32'(transp));
  endtask

  // Per-requester index/colour used in the fairness run: req0 idx1, req1 idx13, req2 idx0, req3 idx5.
  logic [23:0] fairColor [4];

  initial begin
    fairColor[0] = 24'hb6b3b1;
    fairColor[1] = 24'he1e1e1;
    fairColor[2] = 24'h000000;
    fairColor[3] = 24'h000000;

    @(negedge i_clk);
    applyStimulus(1'b1, 4'hf, 16'h0000, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("rst_ready_c0", 32'(o_req_ready), 32'h0);
    tick();
    checkOutput("rst_ready_c1", 32'(o_req_ready), 32'h0);
    checkOutput("rst_rspvalid", 32'(o_rsp_valid), 32'h0);
    checkOutput("rst_color", 32'(o_rsp_color), 32'h0);
    tick();
    applyStimulus(1'b0, 4'hf, 16'h0000, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("rel_grant0", 32'(o_req_ready), 32'h1);
    tick();
    checkRsp("rel_rsp", 2'd0, 24'h000000, 1'b1);

    // Load two entries; pointer is 1 after the first grant
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 4'd1, 24'hb6b3b1);
    tick();
    checkOutput("load_rspdrop", 32'(o_rsp_valid), 32'h0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 4'd13, 24'he1e1e1);
    tick();
    applyStimulus(1'b0, 4'h4, 16'h0100, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("load_grant2", 32'(o_req_ready), 32'h4);
    tick();
    checkRsp("load_idx1", 2'd2, 24'hb6b3b1, 1'b0);
    applyStimulus(1'b0, 4'h4, 16'h0000, 1'b1, 1'b0, 4'h0, 24'h0);
    tick();
    checkRsp("load_idx0", 2'd2, 24'h000000, 1'b1);
    applyStimulus(1'b0, 4'h4, 16'h0d00, 1'b1, 1'b0, 4'h0, 24'h0);
    tick();
    checkRsp("load_idx13", 2'd2, 24'he1e1e1, 1'b0);

    // Pointer is 3: a lone req3 grant brings it back to 0
    applyStimulus(1'b0, 4'h8, 16'h50d1, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("ptr_fix_grant3", 32'(o_req_ready), 32'h8);
    tick();

    applyStimulus(1'b0, 4'hf, 16'h50d1, 1'b1, 1'b0, 4'h0, 24'h0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("fair_grant%0d", i), 32'(o_req_ready), 32'(1 << (i % 4)));
      tick();
      checkRsp($sformatf("fair_rsp%0d", i), 2'(i % 4), fairColor[i % 4], 1'(i % 4 == 2));
    end

    // Pointer is 2 with only req1/req3 valid
    applyStimulus(1'b0, 4'ha, 16'h50d1, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("sparse_grant3", 32'(o_req_ready), 32'h8);
    tick();
    checkOutput("sparse_grant1", 32'(o_req_ready), 32'h2);
    tick();
    checkRsp("sparse_rsp1", 2'd1, 24'he1e1e1, 1'b0);

    // Backpressure: pointer 2, req0 granted, then stall three cycles
    applyStimulus(1'b0, 4'h1, 16'h50d1, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("bp_grant0", 32'(o_req_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 4'hf, 16'h50d1, 1'b0, 1'b0, 4'h0, 24'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_ready%0d", i), 32'(o_req_ready), 32'h0);
      checkRsp($sformatf("bp_hold%0d", i), 2'd0, 24'hb6b3b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 4'hf, 16'h50d1, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("bp_resume_grant1", 32'(o_req_ready), 32'h2);
    tick();
    checkRsp("bp_resume_rsp", 2'd1, 24'he1e1e1, 1'b0);

    // Write priority: pointer 2, req0 asks for idx4 while it is being written
    applyStimulus(1'b0, 4'h1, 16'h50d4, 1'b1, 1'b1, 4'd4, 24'h7f7f80);
    checkOutput("wp_nogrant", 32'(o_req_ready), 32'h0);
    tick();
    checkOutput("wp_rspdrop", 32'(o_rsp_valid), 32'h0);
    applyStimulus(1'b0, 4'h1, 16'h50d4, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("wp_grant0", 32'(o_req_ready), 32'h1);
    tick();
    checkRsp("wp_rsp", 2'd0, 24'h7f7f80, 1'b0);

    // A write during a stall commits without altering the held response
    applyStimulus(1'b0, 4'h1, 16'h50d4, 1'b0, 1'b1, 4'd4, 24'h123456);
    tick();
    checkRsp("wstall_hold", 2'd0, 24'h7f7f80, 1'b0);
    applyStimulus(1'b0, 4'h1, 16'h50d4, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("wstall_grant0", 32'(o_req_ready), 32'h1);
    tick();
    checkRsp("wstall_newcolor", 2'd0, 24'h123456, 1'b0);

    // Reset while a response is stalled
    applyStimulus(1'b1, 4'hf, 16'h50d1, 1'b0, 1'b0, 4'h0, 24'h0);
    checkOutput("mrst_ready", 32'(o_req_ready), 32'h0);
    tick();
    checkOutput("mrst_rspvalid", 32'(o_rsp_valid), 32'h0);
    checkOutput("mrst_color", 32'(o_rsp_color), 32'h0);
    applyStimulus(1'b0, 4'hf, 16'h50d1, 1'b1, 1'b0, 4'h0, 24'h0);
    checkOutput("mrst_ptr0", 32'(o_req_ready), 32'h1);
    applyStimulus(1'b0, 4'h1, 16'h0001, 1'b1, 1'b0, 4'h0, 24'h0);
    tick();
    checkRsp("mrst_cleared", 2'd0, 24'h000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
